// File: rtl/dw_add_pipe_pkg.sv
// rtl/dw_add_pipe_pkg.sv - shared op encoding and segment geometry for the segmented adder
package dw_add_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDK = 2'b10,
        OP_INC  = 2'b11
    } op_e;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Lowest bit of segment k, clamped so trailing segments may be empty.
    function automatic int seg_lo(input int k, input int sw, input int width);
        return (k * sw < width) ? k * sw : width;
    endfunction

endpackage

// File: rtl/dw_add_seg.sv
// rtl/dw_add_seg.sv - one registered carry segment of the pipelined adder
module dw_add_seg
    import dw_add_pipe_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          in_valid,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic          out_valid,
    output logic [SW-1:0] sum,
    output logic          co,
    output logic          ci_msb
);

    logic [SW:0]   total;
    logic          valid_d, valid_q;
    logic [SW-1:0] sum_d, sum_q;
    logic          co_d, co_q;
    logic          ci_msb_d, ci_msb_q;

    always_comb begin
        total    = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
        valid_d  = valid_q;
        sum_d    = sum_q;
        co_d     = co_q;
        ci_msb_d = ci_msb_q;
        if (load) begin
            valid_d  = in_valid;
            sum_d    = total[SW-1:0];
            co_d     = total[SW];
            // carry into the top bit recovered from its sum and operand bits
            ci_msb_d = total[SW-1] ^ a[SW-1] ^ b[SW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            ci_msb_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            sum_q    <= sum_d;
            co_q     <= co_d;
            ci_msb_q <= ci_msb_d;
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign co        = co_q;
    assign ci_msb    = ci_msb_q;

endmodule

// File: rtl/dw_add_pipe.sv
// rtl/dw_add_pipe.sv - elastic carry-segmented pipelined adder/subtractor
module dw_add_pipe
    import dw_add_pipe_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] CONST  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int SW = seg_width(WIDTH, STAGES);

    function automatic logic [WIDTH-1:0] seg_mask(input int k);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= seg_lo(k, SW, WIDTH) && i < seg_lo(k + 1, SW, WIDTH)) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [WIDTH-1:0]  b_eff;
    logic              ci_eff;
    logic [STAGES-1:0] load, v_in, c_in, cm_in, vld_o, co_o, cm_o;
    logic [WIDTH-1:0]  acc_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  acc_o [STAGES];
    logic [WIDTH-1:0]  seg_word [STAGES];
    logic [WIDTH-1:0]  acc_d [STAGES];
    logic [WIDTH-1:0]  acc_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];

    always_comb begin
        b_eff  = in_b;
        ci_eff = in_ci;
        case (in_op)
            OP_SUB:  begin b_eff = ~in_b; ci_eff = !in_ci; end
            OP_ADDK: b_eff = CONST;
            OP_INC:  b_eff = '0;
            default: ;
        endcase
    end

    // A stage loads when empty or when its occupant moves on this edge.
    always_comb begin : ready_chain
        logic nxt;
        nxt = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !vld_o[k] || nxt;
            nxt     = load[k];
        end
    end

    // acc words carry finished sum bits below the active segment and pending A bits above it.
    always_comb begin : stage_links
        for (int k = 0; k < STAGES; k++) begin
            acc_o[k] = (acc_q[k] & ~seg_mask(k)) | seg_word[k];
        end
        acc_in[0] = in_a;
        b_in[0]   = b_eff;
        v_in[0]   = in_valid;
        c_in[0]   = ci_eff;
        cm_in[0]  = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            acc_in[k] = acc_o[k-1];
            b_in[k]   = b_q[k-1];
            v_in[k]   = vld_o[k-1];
            c_in[k]   = co_o[k-1];
            cm_in[k]  = cm_o[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            acc_d[k] = load[k] ? acc_in[k] : acc_q[k];
            b_d[k]   = load[k] ? b_in[k] : b_q[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst) begin
                acc_q[k] <= '0;
                b_q[k]   <= '0;
            end else begin
                acc_q[k] <= acc_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, SW, WIDTH);
        localparam int HI = seg_lo(k + 1, SW, WIDTH);

        if (HI > LO) begin : g_seg
            logic [HI-LO-1:0] seg_sum;

            dw_add_seg #(.SW(HI - LO)) u_seg (
                .clk       (clk),
                .rst       (rst),
                .load      (load[k]),
                .in_valid  (v_in[k]),
                .a         (acc_in[k][HI-1:LO]),
                .b         (b_in[k][HI-1:LO]),
                .ci        (c_in[k]),
                .out_valid (vld_o[k]),
                .sum       (seg_sum),
                .co        (co_o[k]),
                .ci_msb    (cm_o[k])
            );

            assign seg_word[k] = WIDTH'(seg_sum) << LO;
        end else begin : g_pass
            // Empty trailing segment when WIDTH/STAGES rounds up: just carry the flags along.
            logic v_d, v_q, c_d, c_q, m_d, m_q;

            always_comb begin
                v_d = v_q;
                c_d = c_q;
                m_d = m_q;
                if (load[k]) begin
                    v_d = v_in[k];
                    c_d = c_in[k];
                    m_d = cm_in[k];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    m_q <= 1'b0;
                end else begin
                    v_q <= v_d;
                    c_q <= c_d;
                    m_q <= m_d;
                end
            end

            assign vld_o[k]    = v_q;
            assign co_o[k]     = c_q;
            assign cm_o[k]     = m_q;
            assign seg_word[k] = '0;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_o[STAGES-1];
    assign out_sum   = acc_o[STAGES-1];
    assign out_co    = co_o[STAGES-1];
    assign out_ovf   = co_o[STAGES-1] ^ cm_o[STAGES-1];

endmodule
